// File: rtl/fwt_pkg.sv
// Shared encodings for the Fenwick tree request arbiter: tree commands,
// sequencer states and result-slot width.
package fwt_pkg;

   typedef enum logic [1:0] {
      CMD_BUILD  = 2'b00,
      CMD_QUERY  = 2'b01,
      CMD_UPDATE = 2'b10,
      CMD_NILL   = 2'b11
   } cmd_e;

   typedef enum logic [2:0] {
      IDLE, BUILD, Q_ISSUE, Q_READ, Q_CAPT, UPD, RESP
   } state_e;

   localparam int SLOT_W = 2;

endpackage

// File: rtl/fwt_rr_arbiter.sv
// Two-way round-robin grant. While lock is high the grant is pinned to
// lock_id; adv moves priority to the requester other than adv_id.
module fwt_rr_arbiter (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       lock,
   input  logic       lock_id,
   input  logic       adv,
   input  logic       adv_id,
   output logic [1:0] gnt
);

   logic ptr;

   always_ff @(posedge clk) begin
      if (rst)      ptr <= 1'b0;
      else if (adv) ptr <= ~adv_id;
   end

   always_comb begin
      gnt = 2'b00;
      if (lock)              gnt[lock_id] = 1'b1;
      else if (req == 2'b11) gnt[ptr]     = 1'b1;
      else                   gnt          = req;
   end

endmodule

// File: rtl/fwt_req_arbiter.sv
// Two-requester build/query/update sequencer in front of the Fenwick tree core.
// Define FWT_ARB_RANGE_CHECK_EN to reject out-of-range query/update indices.
module fwt_req_arbiter
   import fwt_pkg::*;
#(
   parameter int DATA_SIZE = 32,
   parameter int ARR_SIZE  = 100,
   parameter int IW        = $clog2(ARR_SIZE) + 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [1:0]                req_valid,
   output logic [1:0]                req_ready,
   input  logic [1:0][1:0]           req_cmd,
   input  logic [1:0][IW-1:0]        req_idx,
   input  logic [1:0][IW-1:0]        req_ql,
   input  logic [1:0][IW-1:0]        req_qr,
   input  logic [1:0][DATA_SIZE-1:0] req_data,
   output logic                      rsp_valid,
   output logic                      rsp_id,
   output logic                      rsp_err,
   output logic [DATA_SIZE-1:0]      rsp_data,
   output logic                      t_wen,
   output logic [1:0]                t_cmd,
   output logic [SLOT_W-1:0]         t_addr,
   output logic [IW-1:0]             t_uindex,
   output logic [IW-1:0]             t_ql,
   output logic [IW-1:0]             t_qr,
   output logic [DATA_SIZE-1:0]      t_uvalue,
   output logic [DATA_SIZE-1:0]      t_ivalue,
   input  logic [DATA_SIZE-1:0]      t_out
);

   localparam int            BW        = $clog2(ARR_SIZE + 2);
   localparam logic [BW-1:0] LAST_BEAT = BW'(ARR_SIZE);

   state_e              state;
   logic                own_id, built, pend_err, bad_req, lock, adv, hs_id;
   logic [BW-1:0]       beat_cnt;
   logic [SLOT_W-1:0]   slot;
   logic [1:0]          gnt, hs;

   assign lock = (state == BUILD);
   assign adv  = (state == RESP) || (state == Q_CAPT);

   fwt_rr_arbiter u_rr (
      .clk     (clk),
      .rst     (rst),
      .req     (req_valid),
      .lock    (lock),
      .lock_id (own_id),
      .adv     (adv),
      .adv_id  (own_id),
      .gnt     (gnt)
   );

   always_comb begin
      req_ready = 2'b00;
      if (!rst) begin
         if (state == IDLE)       req_ready = (|req_valid) ? gnt : 2'b11;
         else if (state == BUILD) req_ready = gnt;
      end
   end

   assign hs    = req_valid & req_ready;
   assign hs_id = hs[1];

   always_comb begin
      bad_req = !built;
`ifdef FWT_ARB_RANGE_CHECK_EN
      begin
         localparam logic [IW-1:0] IDX_MAX = IW'(ARR_SIZE);
         if (req_cmd[hs_id] == CMD_QUERY)
            bad_req = bad_req || (req_ql[hs_id] > req_qr[hs_id]) ||
                      (req_ql[hs_id] == '0) || (req_qr[hs_id] > IDX_MAX);
         else
            bad_req = bad_req || (req_idx[hs_id] == '0) || (req_idx[hs_id] > IDX_MAX);
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         own_id    <= 1'b0;
         built     <= 1'b0;
         pend_err  <= 1'b0;
         beat_cnt  <= '0;
         slot      <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_data  <= '0;
         t_wen     <= 1'b0;
         t_cmd     <= CMD_NILL;
         t_addr    <= '0;
         t_uindex  <= '0;
         t_ql      <= '0;
         t_qr      <= '0;
         t_uvalue  <= '0;
         t_ivalue  <= '0;
      end else begin
         t_cmd     <= CMD_NILL;
         t_wen     <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_data  <= '0;
         unique case (state)
            IDLE: if (|hs) begin
               own_id   <= hs_id;
               pend_err <= 1'b0;
               case (req_cmd[hs_id])
                  CMD_BUILD: begin
                     t_cmd    <= CMD_BUILD;
                     t_wen    <= 1'b1;
                     t_ivalue <= req_data[hs_id];
                     beat_cnt <= BW'(1);
                     state    <= BUILD;
                  end
                  CMD_QUERY: begin
                     pend_err <= bad_req;
                     if (bad_req) state <= RESP;
                     else begin
                        t_cmd <= CMD_QUERY;
                        t_wen <= 1'b1;
                        t_addr <= slot;
                        t_ql  <= req_ql[hs_id];
                        t_qr  <= req_qr[hs_id];
                        state <= Q_ISSUE;
                     end
                  end
                  CMD_UPDATE: begin
                     pend_err <= bad_req;
                     if (bad_req) state <= RESP;
                     else begin
                        t_cmd    <= CMD_UPDATE;
                        t_wen    <= 1'b1;
                        t_uindex <= req_idx[hs_id];
                        t_uvalue <= req_data[hs_id];
                        state    <= UPD;
                     end
                  end
                  default: state <= RESP;
               endcase
            end
            // every beat from the owner counts, whatever its cmd field says
            BUILD: if (|hs) begin
               t_cmd    <= CMD_BUILD;
               t_wen    <= 1'b1;
               t_ivalue <= req_data[own_id];
               beat_cnt <= beat_cnt + 1'b1;
               if (beat_cnt == LAST_BEAT) begin
                  built <= 1'b1;
                  state <= UPD;
               end
            end
            Q_ISSUE: state <= Q_READ;
            Q_READ:  state <= Q_CAPT;
            Q_CAPT: begin
               rsp_valid <= 1'b1;
               rsp_id    <= own_id;
               rsp_data  <= t_out;
               slot      <= slot + 1'b1;
               state     <= IDLE;
            end
            // last build beat and update both give the tree one write cycle
            UPD: state <= RESP;
            RESP: begin
               rsp_valid <= 1'b1;
               rsp_id    <= own_id;
               rsp_err   <= pend_err;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fwt_req_arbiter.sv
// Directed bench for fwt_req_arbiter with a behavioral tree core model
// (build beat b lands at index b+1, query sums indices ql..qr inclusive).
module tb_fwt_req_arbiter;
   import fwt_pkg::*;

   localparam int DATA_SIZE = 32;
   localparam int ARR_SIZE  = 100;
   localparam int IW        = $clog2(ARR_SIZE) + 2;

   logic                      clk = 1'b0;
   logic                      rst;
   logic [1:0]                req_valid, req_ready;
   logic [1:0][1:0]           req_cmd;
   logic [1:0][IW-1:0]        req_idx, req_ql, req_qr;
   logic [1:0][DATA_SIZE-1:0] req_data;
   logic                      rsp_valid, rsp_id, rsp_err;
   logic [DATA_SIZE-1:0]      rsp_data, t_uvalue, t_ivalue, t_out;
   logic                      t_wen;
   logic [1:0]                t_cmd;
   logic [SLOT_W-1:0]         t_addr;
   logic [IW-1:0]             t_uindex, t_ql, t_qr;

   int n_chk = 0, n_err = 0;
   int cyc = 0, hs_cyc = 0;
   int rsp_cnt = 0, rsp_cyc = 0, wen_cnt = 0, beat_cnt = 0, bcnt = 0;
   logic                 l_id, l_err;
   logic [DATA_SIZE-1:0] l_data;
   logic [SLOT_W-1:0]    q_addr;
   int                   arr [0:127];
   logic [DATA_SIZE-1:0] slots [0:3];

   fwt_req_arbiter #(.DATA_SIZE(DATA_SIZE), .ARR_SIZE(ARR_SIZE), .IW(IW)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_cmd(req_cmd), .req_idx(req_idx), .req_ql(req_ql), .req_qr(req_qr),
      .req_data(req_data), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_err(rsp_err),
      .rsp_data(rsp_data), .t_wen(t_wen), .t_cmd(t_cmd), .t_addr(t_addr),
      .t_uindex(t_uindex), .t_ql(t_ql), .t_qr(t_qr), .t_uvalue(t_uvalue),
      .t_ivalue(t_ivalue), .t_out(t_out)
   );

   always #5 clk = ~clk;

   function automatic int qsum(input int l, input int r);
      int s = 0;
      for (int i = l; i <= r && i < 128; i++) s += arr[i];
      return s;
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) bcnt <= 0;
      else if (t_wen) begin
         case (t_cmd)
            2'b00: begin
               arr[bcnt + 1] <= int'(t_ivalue);
               bcnt <= (bcnt == ARR_SIZE) ? 0 : bcnt + 1;
            end
            2'b01: slots[t_addr] <= DATA_SIZE'(qsum(int'(t_ql), int'(t_qr)));
            2'b10: arr[int'(t_uindex)] <= int'(t_uvalue);
            default: ;
         endcase
      end
      t_out <= slots[t_addr];
   end

   always @(negedge clk) begin
      if (rsp_valid) begin
         rsp_cnt <= rsp_cnt + 1;
         rsp_cyc <= cyc;
         l_id    <= rsp_id;
         l_err   <= rsp_err;
         l_data  <= rsp_data;
      end
      if (t_wen) wen_cnt <= wen_cnt + 1;
      if (t_wen && t_cmd == 2'b00) beat_cnt <= beat_cnt + 1;
      if (t_wen && t_cmd == 2'b01) q_addr <= t_addr;
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic send(input int id, input logic [1:0] cmd, input int ql, input int qr,
                       input int idx, input int data);
      int n;
      n = 0;
      @(negedge clk);
      req_valid[id] = 1'b1;
      req_cmd[id]   = cmd;
      req_ql[id]    = IW'(ql);
      req_qr[id]    = IW'(qr);
      req_idx[id]   = IW'(idx);
      req_data[id]  = DATA_SIZE'(data);
      #1;
      while (!req_ready[id] && n < 50) begin
         @(negedge clk); #1; n++;
      end
      if (!req_ready[id]) chk("hs_timeout", 0, 1);
      hs_cyc = cyc + 1;
      @(posedge clk); #1;
      req_valid[id] = 1'b0;
   endtask

   task automatic wait_rsp(output int lat);
      int c0, n;
      c0 = rsp_cnt;
      n  = 0;
      while (rsp_cnt == c0 && n < 64) begin
         @(negedge clk); #1; n++;
      end
      if (rsp_cnt == c0) chk("rsp_timeout", 0, 1);
      lat = rsp_cyc - hs_cyc;
   endtask

   task automatic xact(input string tag, input int id, input logic [1:0] cmd, input int ql,
                       input int qr, input int idx, input int data,
                       input int e_lat, input logic e_err, input int e_data);
      int lat;
      send(id, cmd, ql, qr, idx, data);
      wait_rsp(lat);
      chk({tag, "_lat"}, lat, e_lat);
      chk({tag, "_id"}, l_id, id);
      chk({tag, "_err"}, l_err, e_err);
      chk({tag, "_data"}, l_data, e_data);
   endtask

   task automatic chk_rst_outs(input string tag);
      chk({tag, "_rsp_valid"}, rsp_valid, 0);
      chk({tag, "_rsp_id"}, rsp_id, 0);
      chk({tag, "_rsp_err"}, rsp_err, 0);
      chk({tag, "_rsp_data"}, rsp_data, 0);
      chk({tag, "_t_cmd"}, t_cmd, 3);
      chk({tag, "_t_wen"}, t_wen, 0);
      chk({tag, "_t_addr"}, t_addr, 0);
      chk({tag, "_t_ivalue"}, t_ivalue, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int w0, c0, lat, rdy_miss, r1_leak;
      rst = 1'b1; req_valid = '0; req_cmd = '0; req_idx = '0;
      req_ql = '0; req_qr = '0; req_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready", req_ready, 0);
      chk_rst_outs("rst");
      rst = 1'b0;

      // no build yet: rejected, tree untouched
      w0 = wen_cnt;
      xact("pre_q", 0, CMD_QUERY, 1, 25, 0, 0, 1, 1'b1, 0);
      xact("pre_u", 1, CMD_UPDATE, 0, 0, 2, 7, 1, 1'b1, 0);
      chk("pre_no_tree", wen_cnt, w0);
      xact("nill", 1, CMD_NILL, 0, 0, 0, 0, 1, 1'b0, 0);

      // build 1..101 from req 0 while req 1 keeps asking
      rdy_miss = 0; r1_leak = 0; beat_cnt = 0;
      @(negedge clk);
      req_valid[1] = 1'b1; req_cmd[1] = CMD_QUERY; req_ql[1] = IW'(1); req_qr[1] = IW'(1);
      for (int k = 0; k <= ARR_SIZE; k++) begin
         req_valid[0] = 1'b1;
         req_cmd[0]   = (k == 50) ? CMD_QUERY : CMD_BUILD;
         req_data[0]  = DATA_SIZE'(k + 1);
         #1;
         if (!req_ready[0]) rdy_miss++;
         if (req_ready[1]) r1_leak++;
         hs_cyc = cyc + 1;
         @(negedge clk);
      end
      req_valid = 2'b00;
      wait_rsp(lat);
      chk("bld_lat", lat, 2);
      chk("bld_id", l_id, 0);
      chk("bld_err", l_err, 0);
      chk("bld_beats", beat_cnt, ARR_SIZE + 1);
      chk("bld_ready_miss", rdy_miss, 0);
      chk("bld_r1_held", r1_leak, 0);

      xact("q1", 0, CMD_QUERY, 1, 25, 0, 0, 3, 1'b0, 325);
      chk("q1_slot", q_addr, 0);
      xact("upd", 0, CMD_UPDATE, 0, 0, 2, 0, 2, 1'b0, 0);
      xact("q2", 0, CMD_QUERY, 1, 25, 0, 0, 3, 1'b0, 323);
      chk("q2_slot", q_addr, 1);
      xact("q3", 0, CMD_QUERY, 4, 25, 0, 0, 3, 1'b0, 319);
      chk("q3_slot", q_addr, 2);
      xact("q4", 0, CMD_QUERY, 10, 35, 0, 0, 3, 1'b0, 585);
      chk("q4_slot", q_addr, 3);
      xact("q5", 0, CMD_QUERY, 3, 3, 0, 0, 3, 1'b0, 3);
      chk("q5_slot", q_addr, 0);

`ifdef FWT_ARB_RANGE_CHECK_EN
      w0 = wen_cnt;
      xact("rng_q", 0, CMD_QUERY, 30, 5, 0, 0, 1, 1'b1, 0);
      xact("rng_u", 0, CMD_UPDATE, 0, 0, 0, 5, 1, 1'b1, 0);
      chk("rng_no_tree", wen_cnt, w0);
`endif

      // park the pointer on 0, then both ask every cycle
      xact("nill2", 1, CMD_NILL, 0, 0, 0, 0, 1, 1'b0, 0);
      @(negedge clk);
      req_cmd = {CMD_QUERY, CMD_QUERY};
      req_ql[0] = IW'(1);  req_qr[0] = IW'(10);
      req_ql[1] = IW'(20); req_qr[1] = IW'(30);
      req_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         wait_rsp(lat);
         chk("alt_id", l_id, k % 2);
         chk("alt_data", l_data, (k % 2) ? 275 : 53);
      end
      req_valid = 2'b00;

      // reset in the middle of a build burst
      @(negedge clk);
      for (int k = 0; k < 50; k++) begin
         req_valid[0] = 1'b1; req_cmd[0] = CMD_BUILD; req_data[0] = DATA_SIZE'(k + 1);
         @(negedge clk);
      end
      c0 = rsp_cnt;
      rst = 1'b1;
      #1;
      chk("mid_rst_ready", req_ready, 0);
      @(negedge clk);
      chk_rst_outs("mid_rst");
      rst = 1'b0;
      req_valid = 2'b00;
      repeat (4) @(negedge clk);
      chk("mid_rst_no_rsp", rsp_cnt, c0);
      xact("post_rst_q", 0, CMD_QUERY, 1, 25, 0, 0, 1, 1'b1, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
